// File: rtl/aes_encipher_par.sv
`default_nettype none
// ============================================================================
// Module   : aes_encipher_par
// Brief    : AES-128 encipher round engine with SBOX_LANES external S-box words
//            per cycle; round keys come from an external key generator.
//            Optional AES_ENCIPHER_PAR_ZEROIZE_EN scrubs data after handoff.
// Revision : 1.0 - initial release
// ============================================================================
module aes_encipher_par #(
    parameter int SBOX_LANES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [127:0]            plaintext,
    output logic [3:0]              round,
    input  logic [127:0]            round_key,
    input  logic                    key_ready,
    output logic [32*SBOX_LANES-1:0] sboxw,
    input  logic [32*SBOX_LANES-1:0] new_sboxw,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [127:0]            ciphertext
);

    localparam logic [1:0] c_last_step = 2'(4 / SBOX_LANES - 1);
    localparam logic [3:0] c_last_round = 4'd10;

    generate
        if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
            $error("aes_encipher_par: SBOX_LANES must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        SBOX = 3'd2,
        MAIN = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                    r_fsm;
    state_t                    w_fsm_nxt;
    logic [127:0]              r_pt;
    logic [127:0]              r_state;
    logic [3:0]                r_round;
    logic [1:0]                r_sbox_ctr;
    logic [127:0]              w_sub_state;
    logic [32*SBOX_LANES-1:0]  w_sboxw;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Bytes are column-major: byte n sits at row n%4, column n/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Lane l handles word sbox_ctr*SBOX_LANES + l of the state.
    always_comb begin
        w_sboxw     = '0;
        w_sub_state = r_state;
        for (int l = 0; l < SBOX_LANES; l++) begin
            if (r_fsm == SBOX) begin
                w_sboxw[32*l +: 32] = r_state[127 - 32*(int'(r_sbox_ctr)*SBOX_LANES + l) -: 32];
            end
            w_sub_state[127 - 32*(int'(r_sbox_ctr)*SBOX_LANES + l) -: 32] = new_sboxw[32*l +: 32];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            IDLE:    if (in_valid) w_fsm_nxt = INIT;
            INIT:    if (key_ready) w_fsm_nxt = SBOX;
            SBOX:    if (r_sbox_ctr == c_last_step) w_fsm_nxt = MAIN;
            MAIN:    if (key_ready) w_fsm_nxt = (r_round == c_last_round) ? DONE : SBOX;
            DONE:    if (out_ready) w_fsm_nxt = IDLE;
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pt       <= '0;
            r_state    <= '0;
            r_round    <= '0;
            r_sbox_ctr <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_pt       <= plaintext;
                        r_round    <= '0;
                        r_sbox_ctr <= '0;
                    end
                end
                INIT: begin
                    if (key_ready) r_state <= r_pt ^ round_key;
                end
                SBOX: begin
                    r_state <= w_sub_state;
                    if (r_sbox_ctr == c_last_step) begin
                        r_sbox_ctr <= '0;
                        r_round    <= r_round + 4'd1;
                    end else begin
                        r_sbox_ctr <= r_sbox_ctr + 2'd1;
                    end
                end
                MAIN: begin
                    if (key_ready) begin
                        if (r_round == c_last_round) begin
                            r_state <= shift_rows(r_state) ^ round_key;
                        end else begin
                            r_state <= mix_columns(shift_rows(r_state)) ^ round_key;
                        end
                    end
                end
                DONE: begin
`ifdef AES_ENCIPHER_PAR_ZEROIZE_EN
                    if (out_ready) begin
                        r_state <= '0;
                        r_pt    <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_fsm == IDLE);
    assign out_valid = (r_fsm == DONE);
    assign round     = r_round;
    assign sboxw     = w_sboxw;

`ifdef AES_ENCIPHER_PAR_ZEROIZE_EN
    assign ciphertext = out_valid ? r_state : '0;
`else
    assign ciphertext = r_state;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_encipher_par.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_encipher_par
// Brief    : Scoreboard bench driving 1-, 2- and 4-lane instances side by side
//            with an S-box table and key schedule built from GF(2^8) maths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_encipher_par;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
`ifdef AES_ENCIPHER_PAR_ZEROIZE_EN
    localparam logic ZEROIZE = 1'b1;
`else
    localparam logic ZEROIZE = 1'b0;
`endif

    typedef struct packed {
        logic [127:0] ct;
        logic [7:0]   extra;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] plaintext;
    logic         stall_mode;
    logic [7:0]   sbox_tab [256];
    logic [127:0] rk_tab [16];

    logic         ov  [3];
    logic         ir  [3];
    logic         sbz [3];
    logic [3:0]   rnd [3];
    logic [127:0] ctx [3];

    exp_t q0[$], q1[$], q2[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc = 0;
    bit   was_v [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
        logic [32*L-1:0] sw;
        logic [32*L-1:0] nsw;
        logic [127:0]    rk;
        logic            kr;
        int              c0 = 0;
        int              c5 = 0;

        always_comb begin
            nsw = '0;
            for (int b = 0; b < 4*L; b++) nsw[8*b +: 8] = sbox_tab[sw[8*b +: 8]];
        end
        assign rk = rk_tab[rnd[k]];
        // Stall window: first three busy cycles seen at round 0 (INIT) and at round 5 (MAIN).
        assign kr = !(stall_mode && !ir[k] &&
                      ((rnd[k] == 4'd0 && c0 < 3) || (rnd[k] == 4'd5 && c5 < 3)));
        assign sbz[k] = (sw == '0);

        always @(posedge clk) begin
            if (in_valid && ir[k]) begin
                c0 <= 0;
                c5 <= 0;
            end else if (!kr) begin
                if (rnd[k] == 4'd0) c0 <= c0 + 1;
                else                c5 <= c5 + 1;
            end
        end

        aes_encipher_par #(.SBOX_LANES(L)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (in_valid),
            .in_ready   (ir[k]),
            .plaintext  (plaintext),
            .round      (rnd[k]),
            .round_key  (rk),
            .key_ready  (kr),
            .sboxw      (sw),
            .new_sboxw  (nsw),
            .out_valid  (ov[k]),
            .out_ready  (out_ready),
            .ciphertext (ctx[k])
        );
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic int lat_of(input int k);
        case (k)
            0:       return 51;
            1:       return 31;
            default: return 21;
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qfront(input int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void qpop(input int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_tab[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= 10) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk_tab[r] = '0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(posedge clk); #1;
        while (!(ir[0] && ir[1] && ir[2]) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL idle_timeout: in_ready not all high after %0d cycles", n);
        end
    endtask

    task automatic run_vec(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct,
                           input logic stall, input logic push);
        exp_t e;
        wait_idle();
        load_key(key);
        stall_mode = stall;
        e.ct    = ct;
        e.extra = stall ? 8'd6 : 8'd0;
        if (push) begin
            q0.push_back(e);
            q1.push_back(e);
            q2.push_back(e);
        end
        in_valid  = 1'b1;
        plaintext = pt;
        @(posedge clk); #1;
        acc       = cyc;
        in_valid  = 1'b0;
        plaintext = '0;
    endtask

    task automatic wait_drained();
        int n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d results outstanding required 0", q0.size() + q1.size() + q2.size());
            q0.delete(); q1.delete(); q2.delete();
        end
    endtask

    // Monitor: first out_valid cycle checks ciphertext and latency; handshake cycle pops.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (ov[k] && !was_v[k]) begin
                if (qsize(k) == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out_valid dut%0d: got 1 required 0", k);
                end else begin
                    e = qfront(k);
                    chk($sformatf("ct dut%0d", k), ctx[k], e.ct);
                    chki($sformatf("latency dut%0d", k), cyc - acc, lat_of(k) + int'(e.extra));
                end
            end
            if (ov[k] && out_ready && qsize(k) != 0) begin
                e = qfront(k);
                chk($sformatf("ct_at_handshake dut%0d", k), ctx[k], e.ct);
                qpop(k);
            end
            was_v[k] = ov[k];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] exp_ret;
        int n;
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        plaintext  = '0;
        stall_mode = 1'b0;
        for (int r = 0; r < 16; r++) rk_tab[r] = '0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chki($sformatf("rst in_ready dut%0d", k), int'(ir[k]), 1);
            chki($sformatf("rst out_valid dut%0d", k), int'(ov[k]), 0);
            chk($sformatf("rst ciphertext dut%0d", k), ctx[k], '0);
            chki($sformatf("rst round dut%0d", k), int'(rnd[k]), 0);
            chki($sformatf("rst sboxw_zero dut%0d", k), int'(sbz[k]), 1);
        end
        reset = 1'b0;

        // FIPS-197 C.1 vector, no stalls, consumer always ready.
        run_vec(KEY_A, PT_A, CT_A, 1'b0, 1'b1);
        wait_drained();
        @(posedge clk); #1;
        exp_ret = ZEROIZE ? 128'h0 : CT_A;
        for (int k = 0; k < 3; k++) begin
            chki($sformatf("post_hs in_ready dut%0d", k), int'(ir[k]), 1);
            chk($sformatf("post_hs ciphertext dut%0d", k), ctx[k], exp_ret);
        end

        // Appendix B vector with key stalls and a slow consumer.
        out_ready = 1'b0;
        run_vec(KEY_B, PT_B, CT_B, 1'b1, 1'b1);
        n = 0;
        while (!(ov[0] && ov[1] && ov[2]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL done_timeout: out_valid not all high after %0d cycles", n);
        end
        repeat (5) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("hold ciphertext dut%0d", k), ctx[k], CT_B);
                chki($sformatf("hold in_ready dut%0d", k), int'(ir[k]), 0);
                chki($sformatf("hold out_valid dut%0d", k), int'(ov[k]), 1);
                chki($sformatf("hold sboxw_zero dut%0d", k), int'(sbz[k]), 1);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chki($sformatf("release in_ready dut%0d", k), int'(ir[k]), 1);
            chki($sformatf("release out_valid dut%0d", k), int'(ov[k]), 0);
        end
        stall_mode = 1'b0;
        wait_drained();

        // Abort an encryption with reset while the 1-lane engine is in round 4.
        run_vec(KEY_A, PT_A, CT_A, 1'b0, 1'b0);
        n = 0;
        @(negedge clk);
        while (rnd[0] != 4'd4 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL round4_timeout: round got %0d required 4", rnd[0]);
        end
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chki($sformatf("abort out_valid dut%0d", k), int'(ov[k]), 0);
            chki($sformatf("abort in_ready dut%0d", k), int'(ir[k]), 1);
            chk($sformatf("abort ciphertext dut%0d", k), ctx[k], '0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (60) @(negedge clk);

        run_vec(KEY_B, PT_B, CT_B, 1'b0, 1'b1);
        wait_drained();
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
